// File: rtl/mcp4922_rx.sv
// mcp4922_rx: receive-side decoder for the MCP4922 DAC serial stream.
// Oversamples cs/sclk/data in the clk domain and deserialises 16-bit
// frames MSB-first. A frame is accepted only if it is exactly 16 bits long.
// The decoded command and the per-channel holding registers (X = A, Y = B)
// are presented on the outputs.
//
// Optional feature, selected with the macro PAIR_LATCH_EN:
//   When PAIR_LATCH_EN is defined, an X frame is parked in a hidden pending
//   register. The following Y frame then updates X and Y together.
//   When it is undefined, each channel updates independently.
module mcp4922_rx #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [11:0] RESET_VALUE = 12'h800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_pin,
  input  logic        sclk_pin,
  input  logic        data_pin,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        frame_axis,
  output logic        frame_buf,
  output logic        frame_gain,
  output logic        frame_shdn,
  output logic [11:0] frame_value,
  output logic [11:0] x_value,
  output logic [11:0] y_value,
  output logic        busy
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  // The settle counter covers the synchronizer depth plus the edge-detect
  // register. Once it is full, cs_q holds a real port sample and no longer
  // a reset value.
  localparam int                 SETTLE_W   = $clog2(SYNC_STAGES + 2) + 1;
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SYNC_STAGES + 1);

  // Synchronizer chains. Index 0 is nearest to the pin.
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   data_s;

  // Edge-detect stage. Every event is registered, so data_q stays aligned
  // with sclk_rise.
  logic cs_q;
  logic sclk_q;
  logic cs_rise;
  logic cs_fall;
  logic sclk_rise;
  logic data_q;

  logic [SETTLE_W-1:0] settle;
  logic                settled;

  state_t state;
  state_t state_next;

  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_nxt;
  logic [4:0]  cnt_nxt;
  logic        frame_close;
  logic        frame_good;
  logic        frame_bad;

`ifdef PAIR_LATCH_EN
  logic [11:0] x_pending;
`endif

  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign data_s  = data_sync[SYNC_STAGES-1];
  assign settled = (settle == SETTLE_MAX);

  // Shift the three pin samples through equal-depth synchronizer chains.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      data_sync <= '0;
    end else begin
      cs_sync[0]   <= cs_pin;
      sclk_sync[0] <= sclk_pin;
      data_sync[0] <= data_pin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync[i]   <= cs_sync[i-1];
        sclk_sync[i] <= sclk_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
    end
  end

  // Register the synchronized levels and the cs/sclk edge events.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      cs_rise   <= 1'b0;
      cs_fall   <= 1'b0;
      sclk_rise <= 1'b0;
      data_q    <= 1'b0;
    end else begin
      cs_q      <= cs_s;
      sclk_q    <= sclk_s;
      cs_rise   <= cs_s & ~cs_q;
      cs_fall   <= ~cs_s & cs_q;
      sclk_rise <= sclk_s & ~sclk_q;
      data_q    <= data_s;
    end
  end

  // Count cycles after reset until the pipeline holds only real samples.
  // Until then, a fake cs fall left over from the reset values is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle <= '0;
    end else if (!settled) begin
      settle <= settle + SETTLE_W'(1);
    end else begin
      settle <= settle;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic. WAIT_IDLE discards any frame that was already
  // in progress when reset was released.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_IDLE: begin
        if (settled && cs_q) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_IDLE;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_next = IDLE;
        end else begin
          state_next = SHIFT;
        end
      end
      default: begin
        state_next = WAIT_IDLE;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Next shift/count values. A bit that arrives in the same cycle as the
  // cs rise is folded in before the frame is judged.
  always_comb begin
    shift_nxt = shift_reg;
    cnt_nxt   = bit_cnt;
    if ((state == SHIFT) && sclk_rise) begin
      shift_nxt = {shift_reg[14:0], data_q};
      if (bit_cnt >= 5'd17) begin
        cnt_nxt = 5'd17;
      end else begin
        cnt_nxt = bit_cnt + 5'd1;
      end
    end else begin
      shift_nxt = shift_reg;
      cnt_nxt   = bit_cnt;
    end
    frame_close = (state == SHIFT) && cs_rise;
    frame_good  = frame_close && (cnt_nxt == 5'd16);
    frame_bad   = frame_close && (cnt_nxt != 5'd16);
  end

  // Deserializer, frame status pulses and decoded command fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg   <= 16'h0000;
      bit_cnt     <= 5'd0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_axis  <= 1'b0;
      frame_buf   <= 1'b0;
      frame_gain  <= 1'b0;
      frame_shdn  <= 1'b0;
      frame_value <= 12'h000;
    end else begin
      frame_valid <= frame_good;
      frame_error <= frame_bad;
      if ((state == IDLE) && cs_fall) begin
        shift_reg <= 16'h0000;
        bit_cnt   <= 5'd0;
      end else begin
        shift_reg <= shift_nxt;
        bit_cnt   <= cnt_nxt;
      end
      if (frame_good) begin
        frame_axis  <= shift_nxt[15];
        frame_buf   <= shift_nxt[14];
        frame_gain  <= shift_nxt[13];
        frame_shdn  <= shift_nxt[12];
        frame_value <= shift_nxt[11:0];
      end else begin
        frame_axis  <= frame_axis;
        frame_buf   <= frame_buf;
        frame_gain  <= frame_gain;
        frame_shdn  <= frame_shdn;
        frame_value <= frame_value;
      end
    end
  end

`ifdef PAIR_LATCH_EN
  // Channel holding registers. X is parked until the next Y frame arrives,
  // then both registers update in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_pending <= RESET_VALUE;
      x_value   <= RESET_VALUE;
      y_value   <= RESET_VALUE;
    end else if (frame_good) begin
      if (shift_nxt[15]) begin
        y_value   <= shift_nxt[11:0];
        x_value   <= x_pending;
        x_pending <= x_pending;
      end else begin
        x_pending <= shift_nxt[11:0];
        x_value   <= x_value;
        y_value   <= y_value;
      end
    end else begin
      x_pending <= x_pending;
      x_value   <= x_value;
      y_value   <= y_value;
    end
  end
`else
  // Channel holding registers. Each channel takes its own frames directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_value <= RESET_VALUE;
      y_value <= RESET_VALUE;
    end else if (frame_good) begin
      if (shift_nxt[15]) begin
        y_value <= shift_nxt[11:0];
        x_value <= x_value;
      end else begin
        x_value <= shift_nxt[11:0];
        y_value <= y_value;
      end
    end else begin
      x_value <= x_value;
      y_value <= y_value;
    end
  end
`endif

endmodule

// File: doc/mcp4922_rx.md
Name: mcp4922_rx

Overview:
- Receive-side decoder for the MCP4922 DAC serial stream emitted by the vector DAC driver. Used as an on-chip loopback monitor and as a bench-side DAC model.
- Oversamples cs/sclk/data in the system clk domain, deserialises 16-bit frames MSB-first and checks frame length.
- Presents the decoded command plus per-channel holding registers (X = channel A, Y = channel B).

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on each of cs_pin/sclk_pin/data_pin (min 1; all three equal depth)
RESET_VALUE, 12'h800, reset value of x_value/y_value (DAC mid-scale)

Ports:
clk  input  1  system clock; sclk_pin must be <= clk/2 with each level held >= 1 clk cycle
reset  input  1  synchronous, active-high
cs_pin  input  1  chip select, active-low; rising edge ends a frame
sclk_pin  input  1  serial clock; data sampled on rising edge
data_pin  input  1  serial data, MSB first
frame_valid  output  1  one-cycle pulse: well-formed 16-bit frame decoded
frame_error  output  1  one-cycle pulse: frame ended with bit count != 16
frame_axis  output  1  bit 15 of last good frame (0 = X/A, 1 = Y/B)
frame_buf  output  1  bit 14 of last good frame
frame_gain  output  1  bit 13 of last good frame (1 = 1x)
frame_shdn  output  1  bit 12 of last good frame (1 = active)
frame_value  output  12  bits 11:0 of last good frame
x_value  output  12  latest value for channel A
y_value  output  12  latest value for channel B
busy  output  1  high while in SHIFT

Behaviour:
- Reset: state = WAIT_IDLE; shift reg = 0, bit count = 0; frame_valid = frame_error = busy = 0; frame_* = 0; x_value = y_value = RESET_VALUE. Synchronizer flops reset to cs = 1, sclk = 0, data = 0.
- Edge detect operates on synchronized signals only. All three inputs see identical delay, so sampled data aligns with the sclk rise.
- WAIT_IDLE: go to IDLE when synced cs = 1. Ensures a frame already in progress at reset release is discarded silently, with no error.
- IDLE: on synced cs falling edge -> SHIFT, clear bit count.
- SHIFT, busy = 1: on each synced sclk rise, shift data into the LSB of a 16-bit register. Bit count is 5 bits and saturates at 17; counts above 16 are all treated as overflow.
- SHIFT, sclk rise and cs rise in the same cycle: the bit is captured first, then the frame is closed.
- SHIFT, synced cs rising edge -> IDLE:
  - count == 16: frame_valid = 1 for exactly one cycle, the cycle after cs-rise detection. frame_* update in that same cycle. If axis = 0, x_value <= value, else y_value <= value.
  - count != 16 (including 0): frame_error pulses one cycle; frame_*, x_value and y_value are unchanged.
- Latency: frame_valid is high SYNC_STAGES+2 clk cycles after the cycle in which cs_pin rises at the port.
- sclk edges while cs is high are ignored.
- Back-to-back frames: a cs falling edge in the same cycle as the valid pulse is accepted, so no gap cycle is required.
- frame_valid and frame_error are mutually exclusive.

Optional Feature:
PAIR_LATCH_EN
- Defined:
  - An axis = 0 frame loads a hidden x_pending register, and x_value does not change.
  - An axis = 1 frame updates y_value and copies x_pending to x_value in the same cycle. The X/Y pair therefore updates together, avoiding beam skew.
  - x_pending resets to RESET_VALUE.
- Not defined: each channel updates independently as described above.

Test Plan:
- Send frame 16'h7ABC at sclk = clk/2 -> one frame_valid pulse; axis = 0, buf = 1, gain = 1, shdn = 1, frame_value = 12'hABC, x_value = 12'hABC, y_value = 12'h800.
- Send 16'hF123, then 16'h7456 back-to-back with cs high for 1 clk between them -> two frame_valid pulses; y_value = 12'h123, x_value = 12'h456.
- 12-bit frame (cs rises early), then a 17-bit frame -> frame_error pulses twice, no frame_valid; x_value and y_value keep their prior values.
- Assert reset after 8 bits of 16'h7FFF, release reset with cs still low, finish the frame -> no valid pulse, no error pulse; x_value = 12'h800. The next 16'h7001 yields x_value = 12'h001.
- Drive the TX driver (value 12'h3C3, axis 1) into this block -> y_value = 12'h3C3; latency from cs rise to frame_valid = SYNC_STAGES+2 cycles.
- PAIR_LATCH_EN defined: send 16'h7111 -> x_value stays 12'h800. Then send 16'hF222 -> x_value = 12'h111 and y_value = 12'h222 in the same cycle.
